// File: rtl/adc_spi_pkg.sv
// Shared types and elaboration helpers for the multichannel ADC serial reader.
// The top module uses params_ok() to reject illegal parameter sets when the design is elaborated.
package adc_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    QUIET = 2'd3
  } state_t;

  // Minimum number of bits needed to hold the values 0..value-1 (never less than 1).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit params_ok(input int n_ch, input int data_w, input int frame_clks,
                                   input int data_start, input int clk_div,
                                   input int cs_setup, input int cs_hold);
    return (n_ch >= 1) && (n_ch <= 8) && (data_w >= 1) && (data_w <= 24) &&
           (frame_clks >= 2) && (frame_clks <= 64) && (data_start >= 0) &&
           (data_start + data_w <= frame_clks) && (clk_div >= 1) &&
           (cs_setup >= 1) && (cs_hold >= 1);
  endfunction

endpackage

// File: rtl/adc_sdo_capture.sv
// Serial-in/parallel-out capture for one ADC SDO line.
// data_next exposes the value the register will take, so the frame-final sample can be published without delay.
module adc_sdo_capture #(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              sample_en,
  input  logic              window_en,
  input  logic              sdo,
  output logic [DATA_W-1:0] data_next
);

  logic [DATA_W-1:0] shift_reg;

  generate
    if (DATA_W == 1) begin : g_single
      assign data_next = (sample_en && window_en) ? sdo : shift_reg;
    end else begin : g_multi
      assign data_next = (sample_en && window_en) ? {shift_reg[DATA_W-2:0], sdo} : shift_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      shift_reg <= '0;
    end else begin
      shift_reg <= data_next;
    end
  end

endmodule

// File: rtl/adc_spi_multich_rx.sv
// Multichannel ADC serial reader: divided SCLK, N_CH parallel SDO captures, optional config word on SDI.
// Frames are started by an iSYNC rising edge or continuously while iAUTO is high.
module adc_spi_multich_rx
  import adc_spi_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int DATA_W     = 12,
  parameter int FRAME_CLKS = 32,
  parameter int DATA_START = 18,
  parameter int CLK_DIV    = 2,
  parameter int CS_SETUP   = 1,
  parameter int CS_HOLD    = 2,
  parameter logic [FRAME_CLKS-1:0] CFG_WORD = '0
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iSYNC,
  input  logic                     iAUTO,
  input  logic [N_CH-1:0]          iSDO,
  output logic                     oCS_n,
  output logic                     oCLK,
  output logic                     oSDI,
  output logic [N_CH*DATA_W-1:0]   odata,
  output logic                     oVALID,
  output logic                     oBUSY,
  output logic                     oOVERRUN
);

  localparam int CNT_MAX0 = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int CNT_MAX  = (CNT_MAX0 > CS_HOLD) ? CNT_MAX0 : CS_HOLD;
  localparam int CNT_W    = clog2(CNT_MAX);
  localparam int PER_W    = clog2(FRAME_CLKS);

  generate
    if (!params_ok(N_CH, DATA_W, FRAME_CLKS, DATA_START, CLK_DIV, CS_SETUP, CS_HOLD)) begin : g_param_error
      $error("adc_spi_multich_rx: illegal parameter combination");
    end
  endgenerate

  state_t                  state_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [PER_W-1:0]        period_reg;
  logic                    phase_reg;
  logic [FRAME_CLKS-1:0]   sdi_shift_reg;
  logic                    sync_q_reg;
  logic                    cs_n_reg;
  logic                    sclk_reg;
  logic                    sdi_reg;
  logic                    valid_reg;
  logic [N_CH*DATA_W-1:0]  odata_reg;
  logic [N_CH*DATA_W-1:0]  capture_next;

  logic sync_rise;
  logic start_req;
  logic sample_en;
  logic window_en;
  logic last_period;

  assign sync_rise   = iSYNC & ~sync_q_reg;
  assign start_req   = sync_rise | iAUTO;
  // Sampling happens on the cycle whose edge drives SCLK back low.
  assign sample_en   = (state_reg == SHIFT) && phase_reg && (cnt_reg == CNT_W'(CLK_DIV - 1));
  assign window_en   = (int'(period_reg) >= DATA_START) && (int'(period_reg) < DATA_START + DATA_W);
  assign last_period = (period_reg == PER_W'(FRAME_CLKS - 1));

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_capture
      adc_sdo_capture #(
        .DATA_W(DATA_W)
      ) u_capture (
        .clk       (iCLK),
        .srst      (iRST),
        .sample_en (sample_en),
        .window_en (window_en),
        .sdo       (iSDO[gi]),
        .data_next (capture_next[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      period_reg    <= '0;
      phase_reg     <= 1'b0;
      sdi_shift_reg <= '0;
      sync_q_reg    <= 1'b0;
      cs_n_reg      <= 1'b1;
      sclk_reg      <= 1'b0;
      sdi_reg       <= 1'b0;
      valid_reg     <= 1'b0;
      odata_reg     <= '0;
    end else begin
      sync_q_reg <= iSYNC;
      valid_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_req) begin
            state_reg     <= LEAD;
            cnt_reg       <= '0;
            cs_n_reg      <= 1'b0;
            sdi_reg       <= CFG_WORD[FRAME_CLKS-1];
            sdi_shift_reg <= CFG_WORD << 1;
          end
        end
        LEAD: begin
          if (cnt_reg == CNT_W'(CS_SETUP - 1)) begin
            state_reg  <= SHIFT;
            cnt_reg    <= '0;
            phase_reg  <= 1'b0;
            period_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        SHIFT: begin
          if (cnt_reg == CNT_W'(CLK_DIV - 1)) begin
            cnt_reg <= '0;
            if (!phase_reg) begin
              phase_reg <= 1'b1;
              sclk_reg  <= 1'b1;
            end else begin
              phase_reg <= 1'b0;
              sclk_reg  <= 1'b0;
              if (last_period) begin
                state_reg  <= QUIET;
                period_reg <= '0;
                cs_n_reg   <= 1'b1;
                sdi_reg    <= 1'b0;
                odata_reg  <= capture_next;
                valid_reg  <= 1'b1;
              end else begin
                // Next low phase begins: advance the config word one bit.
                period_reg    <= period_reg + PER_W'(1);
                sdi_reg       <= sdi_shift_reg[FRAME_CLKS-1];
                sdi_shift_reg <= sdi_shift_reg << 1;
              end
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        QUIET: begin
          if (cnt_reg == CNT_W'(CS_HOLD - 1)) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign oCS_n    = cs_n_reg;
  assign oCLK     = sclk_reg;
  assign oSDI     = sdi_reg;
  assign odata    = odata_reg;
  assign oVALID   = valid_reg;
  assign oBUSY    = (state_reg != IDLE);
  // Requests that arrive while a frame is in flight are dropped and flagged.
  assign oOVERRUN = sync_rise & ~iAUTO & (state_reg != IDLE);

endmodule

// File: tb/tb_adc_spi_multich_rx.sv
// Directed bench for adc_spi_multich_rx: default instance plus a 4-channel, CLK_DIV=1 instance.
// ADC models drive SDO on each SCLK rise; monitors log frame timing and strobes for later checks.
module tb_adc_spi_multich_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic        sync_a, auto_a, sync_b;
  logic [1:0]  sdo_a;
  logic [3:0]  sdo_b;
  logic        cs_a, sclk_a, sdi_a, valid_a, busy_a, ovr_a;
  logic        cs_b, sclk_b, sdi_b, valid_b, busy_b, ovr_b;
  logic [23:0] data_a;
  logic [63:0] data_b;

  adc_spi_multich_rx dut_a (
    .iCLK(clk), .iRST(rst), .iSYNC(sync_a), .iAUTO(auto_a), .iSDO(sdo_a),
    .oCS_n(cs_a), .oCLK(sclk_a), .oSDI(sdi_a), .odata(data_a),
    .oVALID(valid_a), .oBUSY(busy_a), .oOVERRUN(ovr_a)
  );

  adc_spi_multich_rx #(
    .N_CH(4), .DATA_W(16), .FRAME_CLKS(32), .DATA_START(16), .CLK_DIV(1),
    .CS_SETUP(1), .CS_HOLD(2), .CFG_WORD(32'h8001_0000)
  ) dut_b (
    .iCLK(clk), .iRST(rst), .iSYNC(sync_b), .iAUTO(1'b0), .iSDO(sdo_b),
    .oCS_n(cs_b), .oCLK(sclk_b), .oSDI(sdi_b), .odata(data_b),
    .oVALID(valid_b), .oBUSY(busy_b), .oOVERRUN(ovr_b)
  );

  // Stimulus-owned model controls
  logic [11:0] pat_a [2];
  logic        fill_a;
  bit          auto_inc;
  logic [15:0] pat_b [4];

  // Monitor-owned records for instance A
  logic [11:0] auto_val = '0;
  int          rise_a = 0, cs_fall_a = 0, cs_rise_a = 0, pulses_a = 0;
  int          valid_n_a = 0, ovr_n_a = 0, ovr_cyc_a = 0;
  int          hist_cyc_a [64];
  logic [23:0] hist_dat_a [64];
  logic        cs_a_prev = 1'b1, sclk_a_prev = 1'b0;

  always @(negedge clk) begin
    if (!cs_a && cs_a_prev) begin
      cs_fall_a = cyc;
      if (auto_inc) auto_val = auto_val + 12'd1;
    end
    if (cs_a && !cs_a_prev) begin
      cs_rise_a = cyc;
      pulses_a  = rise_a;
    end
    if (cs_a) begin
      rise_a = 0;
    end else if (sclk_a && !sclk_a_prev) begin
      rise_a++;
      for (int c = 0; c < 2; c++) begin
        logic [11:0] w;
        int k;
        w = auto_inc ? auto_val : pat_a[c];
        k = rise_a - 1;
        sdo_a[c] = (k >= 18 && k < 30) ? w[11-(k-18)] : fill_a;
      end
    end
    if (valid_a) begin
      if (valid_n_a < 64) begin
        hist_cyc_a[valid_n_a] = cyc;
        hist_dat_a[valid_n_a] = data_a;
      end
      valid_n_a++;
    end
    if (ovr_a) begin
      ovr_n_a++;
      ovr_cyc_a = cyc;
    end
    cs_a_prev   = cs_a;
    sclk_a_prev = sclk_a;
  end

  // Monitor-owned records for instance B
  int          rise_b = 0, pulses_b = 0, valid_n_b = 0, valid_cyc_b = 0;
  logic [63:0] valid_dat_b = '0;
  logic [31:0] mask_b = '0;
  logic        cs_b_prev = 1'b1, sclk_b_prev = 1'b0;

  always @(negedge clk) begin
    if (!cs_b && cs_b_prev) mask_b = '0;
    if (cs_b && !cs_b_prev) pulses_b = rise_b;
    if (cs_b) begin
      rise_b = 0;
    end else if (sclk_b && !sclk_b_prev) begin
      rise_b++;
      if (rise_b <= 32) mask_b[rise_b-1] = sdi_b;
      for (int c = 0; c < 4; c++) begin
        logic [15:0] w;
        int k;
        w = pat_b[c];
        k = rise_b - 1;
        sdo_b[c] = (k >= 16 && k < 32) ? w[15-(k-16)] : 1'b0;
      end
    end
    if (valid_b) begin
      valid_n_b++;
      valid_cyc_b = cyc;
      valid_dat_b = data_b;
    end
    cs_b_prev   = cs_b;
    sclk_b_prev = sclk_b;
  end

  int total = 0, passed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input bit on_b, output int t);
    goto(cyc + 1);
    if (on_b) sync_b = 1'b1; else sync_a = 1'b1;
    t = cyc;
    goto(cyc + 1);
    sync_a = 1'b0;
    sync_b = 1'b0;
  endtask

  int t0, t1, ta, vb, ob;

  initial begin
    rst = 1'b1; sync_a = 1'b0; auto_a = 1'b0; sync_b = 1'b0;
    fill_a = 1'b0; auto_inc = 1'b0;
    pat_a[0] = '0; pat_a[1] = '0;
    pat_b[0] = 16'h1234; pat_b[1] = 16'hABCD; pat_b[2] = 16'h0F0F; pat_b[3] = 16'hC3A5;
    sdo_a = '0; sdo_b = '0;
    goto(4);
    rst = 1'b0;
    @(negedge clk);
    check("reset_a", {cs_a, sclk_a, sdi_a, valid_a, busy_a, ovr_a, 40'h0, data_a}, {1'b1, 5'b0, 64'h0});
    check("reset_b", {cs_b, sclk_b, sdi_b, valid_b, busy_b, ovr_b}, 64'h20);
    check("reset_data_b", data_b, 64'h0);

    // Single triggered frame
    pat_a[0] = 12'hA5C; pat_a[1] = 12'h3F0;
    vb = valid_n_a;
    pulse(1'b0, t0);
    goto(t0 + 131); @(negedge clk);
    check("busy_t131", busy_a, 1'b1);
    goto(t0 + 132); @(negedge clk);
    check("busy_t132", busy_a, 1'b0);
    check("cs_fall", cs_fall_a, t0 + 1);
    check("cs_rise", cs_rise_a, t0 + 130);
    check("sclk_pulses", pulses_a, 32);
    check("valid_count", valid_n_a - vb, 1);
    check("valid_cycle", hist_cyc_a[vb], t0 + 130);
    check("frame_data", hist_dat_a[vb], 24'h3F0A5C);

    // Free-running, three frames, iAUTO dropped mid third frame
    vb = valid_n_a;
    goto(cyc + 5);
    auto_inc = 1'b1; auto_a = 1'b1; ta = cyc;
    goto(ta + 324);
    auto_a = 1'b0;
    goto(ta + 600);
    auto_inc = 1'b0;
    check("auto_count", valid_n_a - vb, 3);
    check("auto_cyc1", hist_cyc_a[vb], ta + 130);
    check("auto_cyc2", hist_cyc_a[vb+1], ta + 262);
    check("auto_cyc3", hist_cyc_a[vb+2], ta + 394);
    check("auto_dat1", hist_dat_a[vb], 24'h001001);
    check("auto_dat2", hist_dat_a[vb+1], 24'h002002);
    check("auto_dat3", hist_dat_a[vb+2], 24'h003003);

    // Overrun during a frame
    pat_a[0] = 12'h123; pat_a[1] = 12'h456;
    vb = valid_n_a; ob = ovr_n_a;
    pulse(1'b0, t0);
    goto(t0 + 60);
    sync_a = 1'b1;
    goto(t0 + 61);
    sync_a = 1'b0;
    goto(t0 + 300);
    check("ovr_count", ovr_n_a - ob, 1);
    check("ovr_cycle", ovr_cyc_a, t0 + 60);
    check("ovr_valid_count", valid_n_a - vb, 1);
    check("ovr_valid_cycle", hist_cyc_a[vb], t0 + 130);
    check("ovr_data", hist_dat_a[vb], 24'h456123);

    // Reset mid-frame, then a clean frame
    vb = valid_n_a;
    pulse(1'b0, t0);
    goto(t0 + 70);
    rst = 1'b1;
    goto(t0 + 71);
    rst = 1'b0;
    @(negedge clk);
    check("midreset_outputs", {cs_a, sclk_a, sdi_a, valid_a, busy_a, ovr_a, 40'h0, data_a}, {1'b1, 5'b0, 64'h0});
    goto(t0 + 250);
    check("midreset_no_valid", valid_n_a - vb, 0);
    pat_a[0] = 12'h0F1; pat_a[1] = 12'hE2D;
    pulse(1'b0, t1);
    goto(t1 + 140);
    check("post_reset_count", valid_n_a - vb, 1);
    check("post_reset_cycle", hist_cyc_a[vb], t1 + 130);
    check("post_reset_data", hist_dat_a[vb], 24'hE2D0F1);

    // Four-channel instance with config word
    pulse(1'b1, t0);
    @(negedge clk);
    check("b_lead_sdi", {cs_b, sdi_b}, 2'b01);
    goto(t0 + 66); @(negedge clk);
    check("b_end_strobe", {cs_b, valid_b, sdi_b}, 3'b110);
    goto(t0 + 80);
    check("b_valid_count", valid_n_b, 1);
    check("b_valid_cycle", valid_cyc_b, t0 + 66);
    check("b_data", valid_dat_b, 64'hC3A5_0F0F_ABCD_1234);
    check("b_pulses", pulses_b, 32);
    check("b_sdi_periods", mask_b, 32'h0000_8001);

    // All-zero and all-one words with opposite fill outside the window
    pat_a[0] = 12'h000; pat_a[1] = 12'h000; fill_a = 1'b1;
    vb = valid_n_a;
    pulse(1'b0, t0);
    goto(t0 + 140);
    check("zeros_fill1", hist_dat_a[vb], 24'h000000);
    pat_a[0] = 12'hFFF; pat_a[1] = 12'hFFF; fill_a = 1'b0;
    pulse(1'b0, t0);
    goto(t0 + 140);
    check("ones_fill0", hist_dat_a[vb+1], 24'hFFFFFF);
    check("edge_case_count", valid_n_a - vb, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
